// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// One transaction in flight; data has priority, bounded by a fetch starvation limit.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ready,
  output logic        o_if_valid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_wen,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_mask,
  output logic        o_d_ready,
  output logic        o_d_valid,
  output logic [31:0] o_d_rdata,
  output logic        o_mem_req,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic        own_d;
  logic        lat_wen;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_mask;

  logic starved;
  logic grant_d;
  logic grant_if;
  logic issue;
  logic done;

  assign starved  = (starve_cnt == LIMIT) && i_if_req;
  assign grant_d  = (state == IDLE) && i_d_req && !starved;
  assign grant_if = (state == IDLE) && i_if_req && !grant_d;
  assign issue    = (state == ISSUE);
  assign done     = (state == WAIT) && i_mem_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      own_d      <= 1'b0;
      lat_wen    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_mask   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= ISSUE;
            own_d     <= 1'b1;
            lat_wen   <= i_d_wen;
            lat_addr  <= i_d_addr;
            lat_wdata <= i_d_wdata;
            lat_mask  <= i_d_mask;
            if (i_if_req && starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_if) begin
            state      <= ISSUE;
            own_d      <= 1'b0;
            lat_wen    <= 1'b0;
            lat_addr   <= i_if_addr;
            lat_wdata  <= '0;
            lat_mask   <= 4'b1111;
            starve_cnt <= '0;
          end
        end
        ISSUE: if (i_mem_ready) state <= WAIT;
        WAIT:  if (i_mem_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_if_ready  = grant_if;
  assign o_d_ready   = grant_d;
  assign o_if_valid  = done && !own_d;
  assign o_d_valid   = done && own_d;
  assign o_if_rdata  = (done && !own_d) ? i_mem_rdata : '0;
  assign o_d_rdata   = (done && own_d) ? i_mem_rdata : '0;

  // Memory bus is quiet except while presenting the latched request
  assign o_mem_req   = issue;
  assign o_mem_ren   = issue && !lat_wen;
  assign o_mem_wen   = issue && lat_wen;
  assign o_mem_addr  = issue ? {lat_addr[31:2], 2'b00} : '0;
  assign o_mem_wdata = issue ? lat_wdata : '0;
  assign o_mem_mask  = issue ? lat_mask : '0;
  assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table
// plus hand sequences for starvation and mid-transaction reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready, if_valid;
  logic [31:0] if_rdata;
  logic        d_req, d_wen;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_mask;
  logic        d_ready, d_valid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ready, mem_valid;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_ready(if_ready), .o_if_valid(if_valid),
    .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_wen(d_wen),
    .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .i_d_mask(d_mask),
    .o_d_ready(d_ready), .o_d_valid(d_valid),
    .o_d_rdata(d_rdata),
    .o_mem_req(mem_req), .o_mem_ren(mem_ren),
    .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_ready(mem_ready), .i_mem_valid(mem_valid),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic [3:0]  dm;
    logic        mr;
    logic        mv;
    logic [31:0] mrd;
    logic [7:0]  fl;
    logic [31:0] maddr;
    logic [3:0]  mmask;
    logic [31:0] mwdata;
    logic [31:0] ifrd;
    logic [31:0] drd;
    logic        cdrd;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t v(
    input logic ifr, input logic [31:0] ifa,
    input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dd,
    input logic [3:0] dm, input logic mr,
    input logic mv, input logic [31:0] mrd,
    input logic [7:0] fl, input logic [31:0] maddr,
    input logic [3:0] mmask, input logic [31:0] mwdata,
    input logic [31:0] ifrd, input logic [31:0] drd,
    input logic cdrd);
    vec_t r;
    r.ifr = ifr; r.ifa = ifa; r.dr = dr; r.dw = dw;
    r.da = da; r.dd = dd; r.dm = dm; r.mr = mr;
    r.mv = mv; r.mrd = mrd; r.fl = fl;
    r.maddr = maddr; r.mmask = mmask;
    r.mwdata = mwdata; r.ifrd = ifrd; r.drd = drd;
    r.cdrd = cdrd;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] flags();
    return {if_ready, if_valid, d_ready, d_valid,
            mem_req, mem_ren, mem_wen, busy};
  endfunction

  task automatic idle_in();
    if_req = 0; if_addr = 0;
    d_req = 0; d_wen = 0; d_addr = 0;
    d_wdata = 0; d_mask = 0;
    mem_ready = 0; mem_valid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_in();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    vecs[0]  = v(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0,
                 8'b1000_0000, 0, 0, 0, 0, 0, 1);
    vecs[1]  = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                 8'b0000_1101, 32'h100, 4'hF, 0, 0, 0, 1);
    vecs[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093,
                 8'b0100_0001, 0, 0, 0, 32'h00500093, 0, 1);
    vecs[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 8'b0000_0000, 0, 0, 0, 0, 0, 1);
    vecs[4]  = v(1, 32'h200, 1, 0, 32'h2002, 0, 4'hC, 0, 0, 0,
                 8'b0010_0000, 0, 0, 0, 0, 0, 1);
    vecs[5]  = v(1, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0,
                 8'b0000_1101, 32'h2000, 4'hC, 0, 0, 0, 1);
    vecs[6]  = v(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h11223344,
                 8'b0001_0001, 0, 0, 0, 0, 32'h11223344, 1);
    vecs[7]  = v(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0,
                 8'b1000_0000, 0, 0, 0, 0, 0, 1);
    vecs[8]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 8'b0000_1101, 32'h200, 4'hF, 0, 0, 0, 1);
    vecs[9]  = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                 8'b0000_1101, 32'h200, 4'hF, 0, 0, 0, 1);
    vecs[10] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 8'b0000_0001, 0, 0, 0, 0, 0, 1);
    vecs[11] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEBABE,
                 8'b0100_0001, 0, 0, 0, 32'hCAFEBABE, 0, 1);
    vecs[12] = v(0, 0, 1, 1, 32'h3003, 32'hAB000000, 4'h8, 0, 0, 0,
                 8'b0010_0000, 0, 0, 0, 0, 0, 1);
    vecs[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77,
                 8'b0000_1011, 32'h3000, 4'h8, 32'hAB000000, 0, 0, 1);
    vecs[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 8'b0000_1011, 32'h3000, 4'h8, 32'hAB000000, 0, 0, 1);
    vecs[15] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 8'b0000_1011, 32'h3000, 4'h8, 32'hAB000000, 0, 0, 1);
    vecs[16] = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                 8'b0000_1011, 32'h3000, 4'h8, 32'hAB000000, 0, 0, 1);
    vecs[17] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,
                 8'b0001_0001, 0, 0, 0, 0, 0, 0);
    vecs[18] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55,
                 8'b0000_0000, 0, 0, 0, 0, 0, 1);
    vecs[19] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                 8'b0000_0000, 0, 0, 0, 0, 0, 1);

    rst_n = 0;
    idle_in();
    #12;
    chk("reset_flags", 32'(flags()), 0);
    chk("reset_addr", mem_addr, 0);
    chk("reset_mask", 32'(mem_mask), 0);
    @(negedge clk);
    rst_n = 1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
      d_req = vecs[i].dr; d_wen = vecs[i].dw;
      d_addr = vecs[i].da; d_wdata = vecs[i].dd;
      d_mask = vecs[i].dm;
      mem_ready = vecs[i].mr; mem_valid = vecs[i].mv;
      mem_rdata = vecs[i].mrd;
      @(negedge clk);
      chk($sformatf("v%0d_flags", i), 32'(flags()), 32'(vecs[i].fl));
      chk($sformatf("v%0d_maddr", i), mem_addr, vecs[i].maddr);
      chk($sformatf("v%0d_mmask", i), 32'(mem_mask), 32'(vecs[i].mmask));
      chk($sformatf("v%0d_mwdata", i), mem_wdata, vecs[i].mwdata);
      chk($sformatf("v%0d_ifrdata", i), if_rdata, vecs[i].ifrd);
      if (vecs[i].cdrd)
        chk($sformatf("v%0d_drdata", i), d_rdata, vecs[i].drd);
    end

    // Starvation: fetch and data both requesting continuously
    do_reset();
    begin
      logic [9:0] got;
      logic [9:0] exp_g;
      int ng;
      got = '0;
      ng = 0;
      exp_g = 10'b10000_10000;
      @(posedge clk); #1;
      if_req = 1; if_addr = 32'h400;
      d_req = 1; d_wen = 0; d_addr = 32'h500; d_mask = 4'hF;
      mem_ready = 1; mem_valid = 1; mem_rdata = 32'h1;
      for (int c = 0; c < 100 && ng < 10; c++) begin
        @(negedge clk);
        if (if_ready && d_ready) begin
          n_chk++; n_fail++;
          $display("FAIL dual_grant: both readies high");
        end
        if (if_ready || d_ready) begin
          got[ng] = if_ready;
          ng++;
        end
      end
      chk("starve_count", 32'(ng), 10);
      chk("starve_order", 32'(got), 32'(exp_g));
    end

    // Reset asserted while waiting for memory response
    do_reset();
    @(posedge clk); #1;
    d_req = 1; d_addr = 32'h40; d_mask = 4'hF;
    @(negedge clk);
    chk("rst_seq_dready", 32'(d_ready), 1);
    @(posedge clk); #1;
    d_req = 0; mem_ready = 1;
    @(negedge clk);
    chk("rst_seq_memreq", 32'(mem_req), 1);
    @(posedge clk); #1;
    mem_ready = 0;
    @(negedge clk);
    chk("rst_seq_wait_busy", 32'(busy), 1);
    #1;
    rst_n = 0; mem_valid = 1; mem_rdata = 32'h99;
    #1;
    chk("rst_seq_in_rst", 32'(flags()), 0);
    chk("rst_seq_in_rst_rd", d_rdata, 0);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_seq_stale", 32'(flags()), 0);
    @(posedge clk); #1;
    mem_valid = 0; if_req = 1; if_addr = 32'h80;
    @(negedge clk);
    chk("rst_seq_ifready", 32'(if_ready), 1);
    @(posedge clk); #1;
    if_req = 0; mem_ready = 1;
    @(negedge clk);
    chk("rst_seq_maddr", mem_addr, 32'h80);
    @(posedge clk); #1;
    mem_ready = 0; mem_valid = 1; mem_rdata = 32'h1234;
    @(negedge clk);
    chk("rst_seq_ifvalid", 32'(if_valid), 1);
    chk("rst_seq_ifrdata", if_rdata, 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
